// File: rtl/sram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared types and constants for the SRAM arbiter/controller slice.
//   - sram_state_e : controller FSM states (IDLE, SETUP, ACCESS, HOLD)
//   - SRAM_*_DEF   : default address/data width and wait-state count
//   - WAIT_CNT_W   : width of the ACCESS-phase wait down-counter
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package sram_ctrl_pkg;

    localparam int SRAM_AW_DEF   = 12;
    localparam int SRAM_DW_DEF   = 8;
    localparam int SRAM_WAIT_DEF = 2;
    localparam int WAIT_CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } sram_state_e;

endpackage

// File: rtl/sram_arbiter_ctrl_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_ctrl_if
// One requester port of the SRAM controller.
//   req    : request, held by the requester until ack
//   we     : 1 = write, 0 = read (valid with req)
//   addr   : access address
//   wdata  : write data
//   ack    : one-cycle pulse, request accepted and inputs latched
//   rvalid : one-cycle pulse, rdata valid (reads only)
//   rdata  : read data, held until the next read on this port
// Modports: master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface sram_arbiter_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int AW = SRAM_AW_DEF,
    parameter int DW = SRAM_DW_DEF
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input  ack, rvalid, rdata);
    modport slave  (input  req, we, addr, wdata, output ack, rvalid, rdata);
endinterface

// File: rtl/sram_arb2.sv
// -----------------------------------------------------------------------------
// sram_arb2
// Two-way arbiter for the SRAM controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : pending requests (bit N = port N)
//   advance    : strobe, the current grant is being taken this cycle
//   grant[1:0] : one-hot grant, combinational from req (and pointer)
// Build option SRAM_ARB_ROUND_ROBIN_EN: round-robin with a 1-bit pointer that
// names the port after the last winner. Default build: fixed priority, port 0
// wins ties, and no pointer register exists.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sram_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic ptr_reg;

    // After port 0 wins the pointer moves to 1, after port 1 back to 0,
    // which is exactly grant[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= 1'b0;
        end else if (advance && (|grant)) begin
            ptr_reg <= grant[0];
        end
    end

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant          = 2'b00;
            grant[ptr_reg] = 1'b1;
        end
    end
`else
    assign grant = {req[1] & ~req[0], req[0]};

    // Clock, reset and advance only matter for the round-robin pointer.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, advance};
`endif

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// sram_arbiter_ctrl
// Shares an external asynchronous SRAM between two requesters. Sequences
// CSB/WRB/address/data through IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> HOLD
// and returns read data. The bidirectional data bus is split into o/oe/i; the
// tristate buffer lives in the chip top level.
// Parameters: AW (address width), DW (data width), WAIT_CYCLES (1..15).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   p0, p1        : requester ports (sram_arbiter_ctrl_if.slave)
//   sram_csb      : active-low chip select (registered)
//   sram_wrb      : active-low write strobe (registered)
//   sram_abus     : address (registered)
//   sram_dbus_o   : write data (registered)
//   sram_dbus_oe  : 1 = FPGA drives the data bus (registered)
//   sram_dbus_i   : data bus input, sampled on the edge leaving ACCESS
// Build option SRAM_ARB_ROUND_ROBIN_EN selects round-robin arbitration in
// sram_arb2; otherwise port 0 has fixed priority.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sram_arbiter_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int AW          = SRAM_AW_DEF,
    parameter int DW          = SRAM_DW_DEF,
    parameter int WAIT_CYCLES = SRAM_WAIT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    sram_arbiter_ctrl_if.slave        p0,
    sram_arbiter_ctrl_if.slave        p1,
    output logic                      sram_csb,
    output logic                      sram_wrb,
    output logic [AW-1:0]             sram_abus,
    output logic [DW-1:0]             sram_dbus_o,
    output logic                      sram_dbus_oe,
    input  logic [DW-1:0]             sram_dbus_i
);

    // Counter is loaded with WAIT_CYCLES-1 so ACCESS lasts WAIT_CYCLES cycles.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

    sram_state_e           state_reg, state_next;
    logic [WAIT_CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic                  sel_reg, sel_next;
    logic                  we_reg, we_next;
    logic                  csb_reg, csb_next;
    logic                  wrb_reg, wrb_next;
    logic                  oe_reg, oe_next;
    logic [AW-1:0]         abus_reg, abus_next;
    logic [DW-1:0]         dbus_o_reg, dbus_o_next;
    logic [1:0]            ack_reg, ack_next;
    logic [1:0]            rvalid_reg, rvalid_next;
    logic [DW-1:0]         rdata_reg [2];
    logic                  capture;

    logic [1:0]            req;
    logic [1:0]            grant;
    logic                  arb_advance;

    assign req         = {p1.req, p0.req};
    assign arb_advance = (state_reg == IDLE) && (|req);

    sram_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (arb_advance),
        .grant   (grant)
    );

    // Next-state and next-output logic. All SRAM pins are decoded from the
    // next state and registered, so nothing reaches the pins combinationally.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        sel_next      = sel_reg;
        we_next       = we_reg;
        abus_next     = abus_reg;
        dbus_o_next   = dbus_o_reg;
        ack_next      = 2'b00;
        rvalid_next   = 2'b00;
        capture       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next  = SETUP;
                    sel_next    = grant[1];
                    we_next     = grant[1] ? p1.we    : p0.we;
                    abus_next   = grant[1] ? p1.addr  : p0.addr;
                    dbus_o_next = grant[1] ? p1.wdata : p0.wdata;
                    ack_next    = grant;
                end
            end
            SETUP: begin
                state_next    = ACCESS;
                wait_cnt_next = WAIT_LOAD;
            end
            ACCESS: begin
                if (wait_cnt_reg == '0) begin
                    state_next = HOLD;
                    if (!we_reg) begin
                        capture              = 1'b1;
                        rvalid_next[sel_reg] = 1'b1;
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg - 1'b1;
                end
            end
            HOLD: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        csb_next = 1'b1;
        wrb_next = 1'b1;
        oe_next  = 1'b0;
        case (state_next)
            SETUP: begin
                csb_next = 1'b0;
            end
            ACCESS: begin
                csb_next = 1'b0;
                wrb_next = ~we_next;
                oe_next  = we_next;
            end
            HOLD: begin
                // WRB rises entering HOLD; data stays driven one more cycle.
                csb_next = 1'b0;
                oe_next  = we_next;
            end
            default: begin
                csb_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            sel_reg      <= 1'b0;
            we_reg       <= 1'b0;
            csb_reg      <= 1'b1;
            wrb_reg      <= 1'b1;
            oe_reg       <= 1'b0;
            abus_reg     <= '0;
            dbus_o_reg   <= '0;
            ack_reg      <= 2'b00;
            rvalid_reg   <= 2'b00;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            sel_reg      <= sel_next;
            we_reg       <= we_next;
            csb_reg      <= csb_next;
            wrb_reg      <= wrb_next;
            oe_reg       <= oe_next;
            abus_reg     <= abus_next;
            dbus_o_reg   <= dbus_o_next;
            ack_reg      <= ack_next;
            rvalid_reg   <= rvalid_next;
        end
    end

    // Per-port read data holding registers.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_reg[gi] <= '0;
                end else if (capture && (sel_reg == 1'(gi))) begin
                    rdata_reg[gi] <= sram_dbus_i;
                end
            end
        end
    endgenerate

    assign sram_csb     = csb_reg;
    assign sram_wrb     = wrb_reg;
    assign sram_dbus_oe = oe_reg;
    assign sram_abus    = abus_reg;
    assign sram_dbus_o  = dbus_o_reg;

    assign p0.ack    = ack_reg[0];
    assign p1.ack    = ack_reg[1];
    assign p0.rvalid = rvalid_reg[0];
    assign p1.rvalid = rvalid_reg[1];
    assign p0.rdata  = rdata_reg[0];
    assign p1.rdata  = rdata_reg[1];

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter_ctrl
// Directed bench for sram_arbiter_ctrl. Three controller instances share one
// 100 MHz clock and reset: index 0 uses WAIT_CYCLES=2 for the main sequence,
// indices 1 and 2 use WAIT_CYCLES=1 and 15. Each instance has a behavioural
// SRAM that latches on the WRB rising edge and flags address-setup violations
// (< 10 ns from address change to WRB rise).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_arbiter_ctrl;
    import sram_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]  p0_req, p0_we, p1_req, p1_we;
    logic [11:0] p0_addr [3];
    logic [11:0] p1_addr [3];
    logic [7:0]  p0_wdata [3];
    logic [7:0]  p1_wdata [3];
    logic [2:0]  p0_ack, p0_rvalid, p1_ack, p1_rvalid;
    logic [7:0]  p0_rdata [3];
    logic [7:0]  p1_rdata [3];
    logic [2:0]  csb, wrb, oe;
    logic [11:0] abus [3];
    logic [7:0]  dbus_o [3];
    logic [7:0]  dbus_i [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g
            sram_arbiter_ctrl_if #(.AW(12), .DW(8)) p0 ();
            sram_arbiter_ctrl_if #(.AW(12), .DW(8)) p1 ();

            assign p0.req   = p0_req[gi];
            assign p0.we    = p0_we[gi];
            assign p0.addr  = p0_addr[gi];
            assign p0.wdata = p0_wdata[gi];
            assign p1.req   = p1_req[gi];
            assign p1.we    = p1_we[gi];
            assign p1.addr  = p1_addr[gi];
            assign p1.wdata = p1_wdata[gi];
            assign p0_ack[gi]    = p0.ack;
            assign p0_rvalid[gi] = p0.rvalid;
            assign p0_rdata[gi]  = p0.rdata;
            assign p1_ack[gi]    = p1.ack;
            assign p1_rvalid[gi] = p1.rvalid;
            assign p1_rdata[gi]  = p1.rdata;

            sram_arbiter_ctrl #(
                .AW(12), .DW(8),
                .WAIT_CYCLES((gi == 0) ? 2 : ((gi == 1) ? 1 : 15))
            ) dut (
                .clk          (clk),
                .rst_n        (rst_n),
                .p0           (p0.slave),
                .p1           (p1.slave),
                .sram_csb     (csb[gi]),
                .sram_wrb     (wrb[gi]),
                .sram_abus    (abus[gi]),
                .sram_dbus_o  (dbus_o[gi]),
                .sram_dbus_oe (oe[gi]),
                .sram_dbus_i  (dbus_i[gi])
            );

            // Behavioural asynchronous SRAM
            logic [7:0] mem [4096];
            time        t_addr = 0;
            int         setup_viol = 0;

            always @(abus[gi]) t_addr = $time;

            always @(posedge wrb[gi]) begin
                if (csb[gi] === 1'b0) begin
                    if (($time - t_addr) < 10) setup_viol++;
                    mem[abus[gi]] = dbus_o[gi];
                end
            end

            assign dbus_i[gi] = (csb[gi] === 1'b0 && wrb[gi] === 1'b1 && oe[gi] === 1'b0)
                                ? mem[abus[gi]] : 8'h00;
        end
    endgenerate

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [15:0] tr_csb, tr_wrb, tr_oe, tr_ack, tr_ack_o, tr_rv;
    logic [7:0]  rd_cap, rd1, rd15;
    logic [3:0]  seq;
    int          abus_ok, dbus_ok, n_g, first_k, last_k, na;
    int          wl1, wl15, rk1, rk15, cnt_ack, cnt_rv, cnt_csb;

    initial begin
        rst_n  = 1'b0;
        p0_req = '0; p0_we = '0; p1_req = '0; p1_we = '0;
        for (int i = 0; i < 3; i++) begin
            p0_addr[i] = '0; p1_addr[i] = '0; p0_wdata[i] = '0; p1_wdata[i] = '0;
        end
        repeat (3) @(negedge clk);

        // ---------------- reset state
        chk("rst csb", 32'(csb[0]), 32'd1);
        chk("rst wrb", 32'(wrb[0]), 32'd1);
        chk("rst oe", 32'(oe[0]), 32'd0);
        chk("rst abus", 32'(abus[0]), 32'd0);
        chk("rst dbus_o", 32'(dbus_o[0]), 32'd0);
        chk("rst ack/rvalid", 32'({p0_ack[0], p1_ack[0], p0_rvalid[0], p1_rvalid[0]}), 32'd0);
        chk("rst rdata", 32'({p0_rdata[0], p1_rdata[0]}), 32'd0);
        chk("rst state", 32'(g[0].dut.state_reg), 32'(IDLE));
        $display("reset: outputs idle");
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- single write p0: 0x3A5 <- 0xC7
        p0_req[0] = 1'b1; p0_we[0] = 1'b1; p0_addr[0] = 12'h3A5; p0_wdata[0] = 8'hC7;
        tr_csb = '1; tr_wrb = '1; tr_oe = '0; tr_ack = '0; abus_ok = 0; dbus_ok = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            tr_csb[k-1] = csb[0]; tr_wrb[k-1] = wrb[0]; tr_oe[k-1] = oe[0]; tr_ack[k-1] = p0_ack[0];
            if (!csb[0] && abus[0] == 12'h3A5) abus_ok++;
            if (oe[0] && dbus_o[0] == 8'hC7) dbus_ok++;
            if (p0_ack[0]) p0_req[0] = 1'b0;
        end
        chk("wr csb trace", 32'(tr_csb[7:0]), 32'hF0);
        chk("wr wrb trace", 32'(tr_wrb[7:0]), 32'hF9);
        chk("wr oe trace", 32'(tr_oe[7:0]), 32'h0E);
        chk("wr ack trace", 32'(tr_ack[7:0]), 32'h01);
        chk("wr abus cycles", 32'(abus_ok), 32'd4);
        chk("wr dbus cycles", 32'(dbus_ok), 32'd3);
        chk("wr sram content", 32'(g[0].mem[12'h3A5]), 32'hC7);
        $display("write p0 addr=3a5 data=c7");

        // ---------------- read-back p1: 0x3A5
        p1_req[0] = 1'b1; p1_we[0] = 1'b0; p1_addr[0] = 12'h3A5;
        tr_wrb = '1; tr_oe = '0; tr_ack = '0; tr_ack_o = '0; tr_rv = '0; rd_cap = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            tr_wrb[k-1] = wrb[0]; tr_oe[k-1] = oe[0]; tr_ack[k-1] = p1_ack[0];
            tr_ack_o[k-1] = p0_ack[0]; tr_rv[k-1] = p1_rvalid[0];
            if (p1_rvalid[0]) rd_cap = p1_rdata[0];
            if (p1_ack[0]) p1_req[0] = 1'b0;
        end
        chk("rd rvalid trace", 32'(tr_rv[7:0]), 32'h08);
        chk("rd rdata", 32'(rd_cap), 32'hC7);
        chk("rd wrb trace", 32'(tr_wrb[7:0]), 32'hFF);
        chk("rd oe trace", 32'(tr_oe[7:0]), 32'h00);
        chk("rd p1 ack trace", 32'(tr_ack[7:0]), 32'h01);
        chk("rd p0 ack trace", 32'(tr_ack_o[7:0]), 32'h00);
        chk("rd rdata held", 32'(p1_rdata[0]), 32'hC7);
        $display("read p1 addr=3a5 data=%h", rd_cap);

        // ---------------- contention: both ports request continuously
        p0_req[0] = 1'b1; p0_we[0] = 1'b0; p0_addr[0] = 12'h3A5;
        p1_req[0] = 1'b1; p1_we[0] = 1'b0; p1_addr[0] = 12'h010;
        n_g = 0; seq = '0; first_k = 0; last_k = 0;
        for (int k = 1; k <= 60 && (p0_req[0] || p1_req[0]); k++) begin
            @(negedge clk);
            if (p0_ack[0] || p1_ack[0]) begin
                if (n_g < 4) seq[n_g] = p1_ack[0];
                if (n_g == 0) first_k = k;
                if (n_g == 3) last_k = k;
                n_g++;
                if (n_g >= 4) begin
                    if (p0_ack[0]) p0_req[0] = 1'b0;
                    if (p1_ack[0]) p1_req[0] = 1'b0;
                end
            end
        end
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        chk("contention grant order", 32'(seq), 32'b1010);
`else
        chk("contention grant order", 32'(seq), 32'b0000);
`endif
        chk("contention grant spacing", 32'(last_k - first_k), 32'd15);
        chk("contention drained", 32'({p0_req[0], p1_req[0]}), 32'd0);
        $display("contention: grants (bit=port) %b", seq);
        repeat (6) @(negedge clk);

        // ---------------- back-to-back write/read/write on p0
        p0_req[0] = 1'b1; p0_we[0] = 1'b1; p0_addr[0] = 12'h100; p0_wdata[0] = 8'h5A;
        tr_csb = '1; tr_wrb = '1; tr_oe = '0; tr_ack = '0; tr_rv = '0; na = 0; rd_cap = 8'h00;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            tr_csb[k-1] = csb[0]; tr_wrb[k-1] = wrb[0]; tr_oe[k-1] = oe[0];
            tr_ack[k-1] = p0_ack[0]; tr_rv[k-1] = p0_rvalid[0];
            if (p0_rvalid[0]) rd_cap = p0_rdata[0];
            if (p0_ack[0]) begin
                na++;
                if (na == 1) begin
                    p0_we[0] = 1'b0; p0_addr[0] = 12'h100;
                end else if (na == 2) begin
                    p0_we[0] = 1'b1; p0_addr[0] = 12'h101; p0_wdata[0] = 8'hA5;
                end else begin
                    p0_req[0] = 1'b0;
                end
            end
        end
        chk("b2b csb trace", 32'(tr_csb), 32'hC210);
        chk("b2b wrb trace", 32'(tr_wrb), 32'hE7F9);
        chk("b2b oe trace", 32'(tr_oe), 32'h380E);
        chk("b2b ack trace", 32'(tr_ack), 32'h0421);
        chk("b2b rvalid trace", 32'(tr_rv), 32'h0100);
        chk("b2b rdata", 32'(rd_cap), 32'h5A);
        chk("b2b second write", 32'(g[0].mem[12'h101]), 32'hA5);
        $display("b2b p0: wr 100=5a, rd 100=%h, wr 101=a5", rd_cap);

        // ---------------- WAIT_CYCLES = 1 and 15 instances
        for (int i = 1; i < 3; i++) begin
            p0_req[i] = 1'b1; p0_we[i] = 1'b1; p0_addr[i] = 12'h055; p0_wdata[i] = 8'h3C;
        end
        wl1 = 0; wl15 = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (!wrb[1]) wl1++;
            if (!wrb[2]) wl15++;
            for (int i = 1; i < 3; i++) if (p0_ack[i]) p0_req[i] = 1'b0;
        end
        chk("w1 wrb low width", 32'(wl1), 32'd1);
        chk("w15 wrb low width", 32'(wl15), 32'd15);
        for (int i = 1; i < 3; i++) begin
            p0_req[i] = 1'b1; p0_we[i] = 1'b0;
        end
        rk1 = 0; rk15 = 0; rd1 = 8'h00; rd15 = 8'h00;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (p0_rvalid[1]) begin rk1 = k; rd1 = p0_rdata[1]; end
            if (p0_rvalid[2]) begin rk15 = k; rd15 = p0_rdata[2]; end
            for (int i = 1; i < 3; i++) if (p0_ack[i]) p0_req[i] = 1'b0;
        end
        chk("w1 rvalid cycle", 32'(rk1), 32'd3);
        chk("w15 rvalid cycle", 32'(rk15), 32'd17);
        chk("w1 rdata", 32'(rd1), 32'h3C);
        chk("w15 rdata", 32'(rd15), 32'h3C);
        chk("setup viol w2", 32'(g[0].setup_viol), 32'd0);
        chk("setup viol w1", 32'(g[1].setup_viol), 32'd0);
        chk("setup viol w15", 32'(g[2].setup_viol), 32'd0);
        $display("wait states: w1 wrb=%0d rd=%h, w15 wrb=%0d rd=%h", wl1, rd1, wl15, rd15);

        // ---------------- reset in the middle of a write
        p0_req[0] = 1'b1; p0_we[0] = 1'b1; p0_addr[0] = 12'h200; p0_wdata[0] = 8'h11;
        @(negedge clk);
        if (p0_ack[0]) p0_req[0] = 1'b0;
        @(negedge clk);
        chk("pre-reset wrb low", 32'(wrb[0]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst csb", 32'(csb[0]), 32'd1);
        chk("async rst wrb", 32'(wrb[0]), 32'd1);
        chk("async rst oe", 32'(oe[0]), 32'd0);
        p0_req[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt_ack = 0; cnt_rv = 0; cnt_csb = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (p0_ack[0] || p1_ack[0]) cnt_ack++;
            if (p0_rvalid[0] || p1_rvalid[0]) cnt_rv++;
            if (!csb[0]) cnt_csb++;
        end
        chk("post-rst ack count", 32'(cnt_ack), 32'd0);
        chk("post-rst rvalid count", 32'(cnt_rv), 32'd0);
        chk("post-rst csb low count", 32'(cnt_csb), 32'd0);
        chk("post-rst state", 32'(g[0].dut.state_reg), 32'(IDLE));
        $display("reset mid-write: access abandoned");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
